// File: rtl/branch_resolve_ctrl_if.sv
// Bundles the signals between the branch resolve controller and the fetch/exec pipeline and the predictor.
// Latency: none, this is wiring only.
// Backpressure: only the update channel is throttled (upd_valid/upd_ready); all other signals are unthrottled.
// Ports: stall, f_* (fetch prediction), x_* (exec outcome) and upd_ready are controller inputs.
//        redirect_*, flush, upd_* (queue head) and the two counters are controller outputs.
interface branch_resolve_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             f_valid;
    logic [31:0]      f_pc;
    logic             f_pred_taken;
    logic [31:0]      f_pred_addr;
    logic             x_resolve;
    logic             x_taken;
    logic [31:0]      x_target;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic             upd_valid;
    logic             upd_ready;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic [31:0]      upd_target;
    logic [CNT_W-1:0] mispredict_cnt;
    logic [CNT_W-1:0] drop_cnt;

    // Pipeline / predictor side.
    modport master (
        output stall, f_valid, f_pc, f_pred_taken, f_pred_addr,
        output x_resolve, x_taken, x_target, upd_ready,
        input  redirect_valid, redirect_pc, flush,
        input  upd_valid, upd_pc, upd_taken, upd_target,
        input  mispredict_cnt, drop_cnt
    );

    // Controller side.
    modport slave (
        input  stall, f_valid, f_pc, f_pred_taken, f_pred_addr,
        input  x_resolve, x_taken, x_target, upd_ready,
        output redirect_valid, redirect_pc, flush,
        output upd_valid, upd_pc, upd_taken, upd_target,
        output mispredict_cnt, drop_cnt
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Tracks fetch predictions through D/X, checks them against exec, redirects/flushes on mispredict, queues predictor updates.
// Latency: fetch capture to X slot takes 2 unstalled cycles; resolve to redirect pulse takes 1 cycle; push to upd_valid takes 1 cycle.
// Backpressure: the update queue absorbs upd_ready stalls, and a push into a full queue with no pop is dropped and counted; exec is never stalled.
// Ports: clk, rst (sync, active-high); bus = slave side of branch_resolve_ctrl_if.
module branch_resolve_ctrl #(
    parameter int FIFO_DEPTH   = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_ctrl_if.slave  bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_addr;
    } slot_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } upd_t;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    slot_t             d_q, x_q;
    logic              flush_s;
    logic              resolve;
    logic              mispredict;
    logic              redirect_valid_q;
    logic [31:0]       redirect_pc_q;
    logic [CNT_W-1:0]  mis_cnt_q, drop_cnt_q;

    upd_t              mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_q, wr_q;
    logic [CW-1:0]     cnt_q;
    logic              empty, full, pop, push_ok, drop;
    upd_t              head;

    // Resolution only counts in RUN with a live X slot; during FLUSH the X slot holds wrong-path work.
    assign resolve    = bus.x_resolve && x_q.v && (state_q == RUN);
    assign mispredict = resolve &&
                        ((x_q.pred_taken != bus.x_taken) ||
                         (bus.x_taken && (x_q.pred_addr != bus.x_target)));

    // FSM: the flush window starts with the redirect pulse and lasts FLUSH_CYCLES cycles regardless of stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        flush_s = 1'b0;
        case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d = FLUSH;
                    fcnt_d  = FW'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                flush_s = 1'b1;
                if (fcnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - FW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Tracking slots: flush kills valid bits even while stalled, so wrong-path work cannot survive a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= '0;
            x_q <= '0;
        end else if (flush_s) begin
            d_q.v <= 1'b0;
            x_q.v <= 1'b0;
        end else if (!bus.stall) begin
            d_q <= '{v: bus.f_valid, pc: bus.f_pc, pred_taken: bus.f_pred_taken, pred_addr: bus.f_pred_addr};
            x_q <= d_q;
        end
    end

    // Redirect pulse and corrected PC; the fall-through add wraps at 2^32 naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= mispredict;
            if (mispredict) begin
                redirect_pc_q <= bus.x_taken ? bus.x_target : (x_q.pc + 32'd4);
            end
        end
    end

    // Update queue. A pop in the same cycle frees the slot, so full+push+pop is not a drop.
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign pop     = !empty && bus.upd_ready;
    assign push_ok = resolve && (!full || pop);
    assign drop    = resolve && full && !pop;
    assign head    = mem[rd_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_q] <= '{pc: x_q.pc, taken: bus.x_taken, target: bus.x_target};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop)     rd_q <= rd_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            mis_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (mispredict && (mis_cnt_q != '1)) mis_cnt_q  <= mis_cnt_q + CNT_W'(1);
            if (drop && (drop_cnt_q != '1))      drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush          = flush_s;
    assign bus.upd_valid      = !empty;
    // Head fields read as zero when empty so stale storage never shows on the bus.
    assign bus.upd_pc         = empty ? 32'd0 : head.pc;
    assign bus.upd_taken      = empty ? 1'b0  : head.taken;
    assign bus.upd_target     = empty ? 32'd0 : head.target;
    assign bus.mispredict_cnt = mis_cnt_q;
    assign bus.drop_cnt       = drop_cnt_q;
endmodule
